// File: rtl/osd_wrvec_decoder.sv
// ---------------------------------------------------------------------------
// osd_wrvec_decoder
//
// Purpose:
//   Takes the quasi-static 25-bit OSD write vector that firmware updates from
//   the system clock domain and brings it into the video clock domain. A flip
//   of bit 24 marks a new command. Each command goes into a small FIFO and is
//   then issued to the OSD text RAM or the palette RAM write port. Commands:
//     - text write    : one word into the text RAM, held off while the
//                       display pipeline owns the text RAM port
//     - palette write : one palette entry, never held off
//     - clear         : fills every visible text cell with CLR_CHAR
//   Each retired command toggles wr_ack_o once, so firmware can pace itself.
//
// Ports:
//   VCLK           video clock
//   nVRST          synchronous active-low reset
//   OSDWrVector_i  [24] command toggle, [23] type (0 text, 1 palette),
//                  [22:0] payload
//   rd_busy_i      display readout owns the text RAM port this cycle
//   txt_wren_o     text RAM write strobe
//   txt_wraddr_o   text RAM address {row[3:0], col[5:0]}
//   txt_wrdata_o   text RAM data {colour[3:0], char[7:0]}
//   pal_wren_o     palette write strobe
//   pal_wraddr_o   palette index
//   pal_wrdata_o   palette colour, RGB 6:6:6
//   wr_ack_o       toggles once per retired command
//   busy_o         commands pending or clear sweep running
//   overflow_o     sticky, a command was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module osd_wrvec_decoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          TXT_COLS   = 48,
    parameter int          TXT_ROWS   = 16,
    parameter logic [11:0] CLR_CHAR   = 12'h020
) (
    input  logic        VCLK,
    input  logic        nVRST,
    input  logic [24:0] OSDWrVector_i,
    input  logic        rd_busy_i,
    output logic        txt_wren_o,
    output logic [9:0]  txt_wraddr_o,
    output logic [11:0] txt_wrdata_o,
    output logic        pal_wren_o,
    output logic [3:0]  pal_wraddr_o,
    output logic [17:0] pal_wrdata_o,
    output logic        wr_ack_o,
    output logic        busy_o,
    output logic        overflow_o
);

    localparam int              LP_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LP_AW:0]  LP_FULL_CNT = (LP_AW + 1)'(FIFO_DEPTH);
    localparam logic [6:0]      LP_COLS     = 7'(TXT_COLS);
    localparam logic [5:0]      LP_LAST_COL = 6'(TXT_COLS - 1);
    localparam logic [3:0]      LP_LAST_ROW = 4'(TXT_ROWS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_CLR   = 2'd2;

    // Synchroniser and edge detection
    logic [24:0]      r_s1;
    logic [24:0]      r_s2;
    logic             r_s3;
    logic [1:0]       r_primeCnt;
    logic             r_pushValid;
    logic [23:0]      r_pushData;

    // Command FIFO
    logic [23:0]      r_mem [FIFO_DEPTH];
    logic [LP_AW-1:0] r_wrPtr;
    logic [LP_AW-1:0] r_rdPtr;
    logic [LP_AW:0]   r_count;

    // Issue state machine and clear sweep position
    logic [1:0]       r_state;
    logic [3:0]       r_clrRow;
    logic [5:0]       r_clrCol;

    // Registered outputs
    logic             r_txtWren;
    logic [9:0]       r_txtAddr;
    logic [11:0]      r_txtData;
    logic             r_palWren;
    logic [3:0]       r_palAddr;
    logic [17:0]      r_palData;
    logic             r_ack;
    logic             r_busy;
    logic             r_overflow;

    // Combinational decode of the FIFO head and the issue decision
    logic             w_primed;
    logic             w_detect;
    logic             w_empty;
    logic             w_full;
    logic [23:0]      w_head;
    logic             w_headIsPal;
    logic             w_headIsClr;
    logic             w_headColBad;
    logic             w_sweepLast;
    logic             w_pop;
    logic             w_doTxt;
    logic             w_doPal;
    logic             w_enterClr;
    logic             w_sweepWrite;
    logic             w_pushOk;
    logic             w_drop;
    logic [LP_AW:0]   w_countNext;
    logic [1:0]       w_stateNext;

    // The sync stages come out of reset as zero, so s2 only holds a real
    // sample of the vector from the second edge after reset and s3 from the
    // third. Detection waits until both hold real samples; otherwise a
    // vector whose toggle bit is already 1 would look like a new command.
    assign w_primed = (r_primeCnt == 2'd3);
    assign w_detect = w_primed && (r_s2[24] != r_s3);

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == LP_FULL_CNT);
    assign w_head       = r_mem[r_rdPtr];
    assign w_headIsPal  = w_head[23];
    assign w_headIsClr  = w_head[23] && (w_head[22:19] == 4'hF) && w_head[18];
    assign w_headColBad = ({1'b0, w_head[18:13]} >= LP_COLS);
    assign w_sweepLast  = (r_clrRow == LP_LAST_ROW) && (r_clrCol == LP_LAST_COL);

    // Decide what happens to the FIFO head this cycle. At most one strobe is
    // produced per cycle. Text writes that fall outside the visible columns
    // are retired without a strobe, so they do not wait for the text port.
    always_comb begin
        w_pop        = 1'b0;
        w_doTxt      = 1'b0;
        w_doPal      = 1'b0;
        w_enterClr   = 1'b0;
        w_sweepWrite = 1'b0;
        if (r_state == ST_CLR) begin
            if (!rd_busy_i) begin
                w_sweepWrite = 1'b1;
                w_pop        = w_sweepLast;
            end
        end else if (!w_empty) begin
            if (w_headIsClr) begin
                w_enterClr = 1'b1;
            end else if (w_headIsPal) begin
                w_doPal = 1'b1;
                w_pop   = 1'b1;
            end else if (w_headColBad) begin
                w_pop = 1'b1;
            end else if (!rd_busy_i) begin
                w_doTxt = 1'b1;
                w_pop   = 1'b1;
            end
        end
    end

    // A push into a full FIFO still fits when the head leaves in the same
    // cycle; only a push that finds no room at all is dropped.
    always_comb begin
        w_pushOk    = r_pushValid && (!w_full || w_pop);
        w_drop      = r_pushValid && w_full && !w_pop;
        w_countNext = r_count;
        if (w_pushOk && !w_pop) begin
            w_countNext = r_count + 1'b1;
        end else if (!w_pushOk && w_pop) begin
            w_countNext = r_count - 1'b1;
        end
    end

    // IDLE means nothing buffered, ISSUE means a text or palette entry is at
    // the head, CLR holds the clear entry at the head until its sweep ends.
    always_comb begin
        w_stateNext = ST_IDLE;
        if (w_enterClr) begin
            w_stateNext = ST_CLR;
        end else if ((r_state == ST_CLR) && !w_pop) begin
            w_stateNext = ST_CLR;
        end else if (w_countNext != '0) begin
            w_stateNext = ST_ISSUE;
        end
    end

    // FIFO storage needs no reset: an entry is only read after it was
    // written, and the pointers and count are reset below.
    always_ff @(posedge VCLK) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= r_pushData;
        end
    end

    // Synchroniser, toggle detection and the registered push stage. The
    // push is registered once more so the command enters the FIFO three
    // edges after the vector is first sampled.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= 1'b0;
            r_primeCnt  <= 2'd0;
            r_pushValid <= 1'b0;
            r_pushData  <= '0;
        end else begin
            r_s1        <= OSDWrVector_i;
            r_s2        <= r_s1;
            r_s3        <= r_s2[24];
            if (!w_primed) begin
                r_primeCnt <= r_primeCnt + 2'd1;
            end
            r_pushValid <= w_detect;
            r_pushData  <= r_s2[23:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // State register and clear sweep position. The sweep only moves on
    // cycles where it actually wrote, so a busy display pauses it in place.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_state  <= ST_IDLE;
            r_clrRow <= 4'd0;
            r_clrCol <= 6'd0;
        end else begin
            r_state <= w_stateNext;
            if (w_enterClr) begin
                r_clrRow <= 4'd0;
                r_clrCol <= 6'd0;
            end else if (w_sweepWrite && !w_sweepLast) begin
                if (r_clrCol == LP_LAST_COL) begin
                    r_clrCol <= 6'd0;
                    r_clrRow <= r_clrRow + 4'd1;
                end else begin
                    r_clrCol <= r_clrCol + 6'd1;
                end
            end
        end
    end

    // Write ports, acknowledge and busy. Address and data hold their last
    // value between strobes; the strobes themselves last one cycle. The
    // acknowledge toggles on the same edge as the strobe of the command
    // being retired (or the last sweep write for a clear).
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_txtWren <= 1'b0;
            r_txtAddr <= '0;
            r_txtData <= '0;
            r_palWren <= 1'b0;
            r_palAddr <= '0;
            r_palData <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_txtWren <= w_doTxt || w_sweepWrite;
            r_palWren <= w_doPal;
            if (w_sweepWrite) begin
                r_txtAddr <= {r_clrRow, r_clrCol};
                r_txtData <= CLR_CHAR;
            end else if (w_doTxt) begin
                r_txtAddr <= {w_head[22:19], w_head[18:13]};
                r_txtData <= w_head[11:0];
            end
            if (w_doPal) begin
                r_palAddr <= w_head[22:19];
                r_palData <= w_head[17:0];
            end
            if (w_pop) begin
                r_ack <= ~r_ack;
            end
            r_busy <= (w_countNext != '0) || (w_stateNext == ST_CLR);
        end
    end

    assign txt_wren_o   = r_txtWren;
    assign txt_wraddr_o = r_txtAddr;
    assign txt_wrdata_o = r_txtData;
    assign pal_wren_o   = r_palWren;
    assign pal_wraddr_o = r_palAddr;
    assign pal_wrdata_o = r_palData;
    assign wr_ack_o     = r_ack;
    assign busy_o       = r_busy;
    assign overflow_o   = r_overflow;

endmodule
